// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-port word-addressed data memory: sub-word RMW stores, extended loads.
// Optional feature macro: LSU_BOUNDS_CHECK_EN rejects byte addresses beyond the memory window.
module lsu_mem_master #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t             r_state, w_next;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;
    logic [31:0]        r_word;
    logic [ADDR_W-1:0]  r_mem_a;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic               w_accept;
    logic               w_illegal;
    logic               w_range_err;
    logic               w_we;
    logic [31:0]        w_wd;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = off[0];
            3'd2:    bad = |off;
            3'd4:    bad = we;
            3'd5:    bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'd0:    res = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    res = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (f3[0]) begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
        end else begin
            case (off)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end
        return res;
    endfunction

`ifdef LSU_BOUNDS_CHECK_EN
    assign w_range_err = |req_addr[31:ADDR_W+2];
`else
    assign w_range_err = 1'b0;
`endif

    assign w_illegal = is_illegal(req_we, req_funct3, req_addr[1:0]) | w_range_err;
    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mem_a     = r_mem_a;
    // Reset gates the write strobe so an aborted request never reaches memory.
    assign mem_we    = w_we & ~RST;
    assign mem_wd    = mem_we ? w_wd : 32'd0;

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_wd   = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                w_next = RESP;
                if (r_we) begin
                    if (r_f3[1]) begin
                        w_we = 1'b1;
                        w_wd = r_wdata;
                    end else begin
                        w_next = MERGE;
                    end
                end
            end
            MERGE: begin
                w_we   = 1'b1;
                w_wd   = store_merge(r_word, r_wdata, r_f3, r_off);
                w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_mem_a <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_err   <= w_illegal;
                r_rdata <= 32'd0;
                if (!w_illegal) r_mem_a <= req_addr[ADDR_W+1:2];
            end
            if (r_state == ACCESS && !r_we) r_rdata <= load_extend(mem_rd, r_f3, r_off);
        end
    end

    // Request payload and the RMW snapshot carry no reset; they are only read after a capture.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
        end
        if (r_state == ACCESS) r_word <= mem_rd;
    end

endmodule
